pulse_timer: RTL and testbench
==============================

PULSE_TIMER -- requirements
Module: pulse_timer

Interface
REQ-001 Parameter NCH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter WIDTH, default 8: counter and period width in bits, range 2..32.
REQ-003 Parameter DEFAULT_PERIOD, default 3: period loaded into every channel at reset; must fit in WIDTH bits.
REQ-004 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 en  input  1  global count enable; when low, all counters and state freeze.
REQ-008 start  input  NCH  per-channel arm request; start[i] sets channel i running.
REQ-009 cfg_we  input  1  configuration write strobe.
REQ-010 cfg_ch  input  max(1,$clog2(NCH))  channel index for the configuration write.
REQ-011 cfg_period  input  WIDTH  new period value; the count runs 0..cfg_period inclusive.
REQ-012 cfg_mode  input  1  0 = continuous, 1 = one-shot.
REQ-013 done  output  NCH  per-channel terminal-count flag.
REQ-014 running  output  NCH  per-channel active flag.

Function
REQ-015 Each channel i shall hold count[i] (WIDTH bits), period[i] (WIDTH bits), mode[i] and running[i].
REQ-016 done[i] shall be combinational: (count[i] == period[i]) && running[i].
REQ-017 With en=1 and running[i]=1: if count[i] < period[i], count[i] shall increment by 1; otherwise count[i] shall return to 0.
REQ-018 Continuous mode: running[i] shall stay 1 after each wrap, so done[i] is high for 1 of every period[i]+1 enabled cycles.
REQ-019 One-shot mode: on the enabled cycle where count[i] == period[i], count[i] shall return to 0 and running[i] shall clear, so done[i] is high for exactly one enabled cycle per start.
REQ-020 When en=0, count[i] and running[i] shall hold, and done[i] shall hold its current value.
REQ-021 When running[i]=0, count[i] shall hold at 0 and done[i] shall be 0.
REQ-022 start[i]=1 with running[i]=0 shall set running[i] on the next edge, with count[i]=0; start shall act regardless of en.
REQ-023 start[i]=1 with running[i]=1 shall have no effect; a retrigger does not restart the count.
REQ-024 A configuration write (cfg_we=1, cfg_ch < NCH) shall, on the next edge, load period and mode for that channel, clear its count to 0 and clear its running flag, regardless of en.
REQ-025 A configuration write with cfg_ch >= NCH shall be ignored.
REQ-026 A configuration write and start[i] on the same channel in the same cycle shall apply the new configuration and set running[i]=1 with count[i]=0.
REQ-027 Period 0, continuous mode: done[i] shall be high on every cycle while running.
REQ-028 Period 0, one-shot mode: done[i] shall be high for the single cycle after start, then running[i] shall clear.
REQ-029 Period 2^WIDTH-1: the count shall reach all-ones and then wrap to 0 with no overflow.
REQ-030 Channels shall be fully independent; the only shared inputs are en and the configuration port.

Reset
REQ-031 When rst=1, every channel shall take count=0, period=DEFAULT_PERIOD, mode=continuous and running=1.
REQ-032 rst shall take priority over en, start and cfg_we.
REQ-033 After reset, done shall be all zeros and running all ones, so each channel reproduces the legacy free-running counter with max=DEFAULT_PERIOD.
REQ-034 A reset applied mid-count shall discard the count and any pending one-shot.

Structure
REQ-035 Shared package pulse_pkg shall hold typedef enum mode_e {MODE_CONT, MODE_ONESHOT} and the default-parameter constants.
REQ-036 Sub-module pulse_chan shall implement one channel (count, period, mode, running, done).
REQ-037 pulse_timer shall instantiate NCH copies of pulse_chan through a generate loop and decode cfg_ch into per-channel write enables.

Verification
REQ-038 Reset, then en=1 held for 12 cycles with defaults: every done[i] is high on cycles 4, 8 and 12 after reset release.
REQ-039 Write ch1 with period=5, one-shot, then pulse start[1]: done[1] is high exactly once, 6 enabled cycles after start, then running[1]=0 and the count holds at 0.
REQ-040 Ch0 running with period 3; drop en at count=2 for 5 cycles: count stays 2 and done[0]=0; after en returns, done[0] is high 1 cycle later.
REQ-041 Issue cfg_we to ch2 (period=0, continuous) together with start[2]: done[2] is high on every cycle from the next edge on.
REQ-042 With NCH=3, a write to cfg_ch=3 changes no channel; retriggering start[0] while running leaves the count[0] sequence unchanged.
REQ-043 Assert rst mid-count on a one-shot channel: the channel returns to period=3, continuous mode, running=1 and count=0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and default constants for the multi-channel pulse timer.
// Channel mode encoding and the channel-index width helper live here.
package pulse_pkg;

   typedef enum logic {
      MODE_CONT    = 1'b0,
      MODE_ONESHOT = 1'b1
   } mode_e;

   localparam int unsigned DEF_NCH    = 4;
   localparam int unsigned DEF_WIDTH  = 8;
   localparam int unsigned DEF_PERIOD = 3;

   // Width of the channel-select field; never narrower than one bit.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_chan.sv
// One timer channel: counts 0..period while running, flags terminal count,
// and either wraps (continuous) or stops (one-shot) at the end of a period.
module pulse_chan
   import pulse_pkg::*;
#(
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_period,
   input  mode_e            cfg_mode,
   output logic             done,
   output logic             running
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   mode_e            mode_q, mode_d;
   logic             running_q, running_d;

   // Configuration and arming act regardless of en; configuration wins over
   // counting, and a same-cycle start re-arms the freshly written channel.
   always_comb begin
      count_d   = count_q;
      period_d  = period_q;
      mode_d    = mode_q;
      running_d = running_q;
      if (cfg_we) begin
         period_d  = cfg_period;
         mode_d    = cfg_mode;
         count_d   = '0;
         running_d = start;
      end else if (start && !running_q) begin
         running_d = 1'b1;
         count_d   = '0;
      end else if (en && running_q) begin
         if (count_q < period_q) begin
            count_d = count_q + WIDTH'(1);
         end else begin
            count_d = '0;
            if (mode_q == MODE_ONESHOT) begin
               running_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         period_q  <= WIDTH'(DEFAULT_PERIOD);
         mode_q    <= MODE_CONT;
         running_q <= 1'b1;
      end else begin
         count_q   <= count_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         running_q <= running_d;
      end
   end

   assign done    = running_q && (count_q == period_q);
   assign running = running_q;

endmodule

// File: rtl/pulse_timer.sv
// NCH independent pulse timer channels sharing a global enable and a single
// configuration write port addressed by cfg_ch.
module pulse_timer
   import pulse_pkg::*;
#(
   parameter int unsigned NCH            = DEF_NCH,
   parameter int unsigned WIDTH          = DEF_WIDTH,
   parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NCH-1:0]           start,
   input  logic                     cfg_we,
   input  logic [ch_width(NCH)-1:0] cfg_ch,
   input  logic [WIDTH-1:0]         cfg_period,
   input  logic                     cfg_mode,
   output logic [NCH-1:0]           done,
   output logic [NCH-1:0]           running
);

   localparam int unsigned CW = ch_width(NCH);

   logic [NCH-1:0] cfg_we_ch;
   mode_e          cfg_mode_e;

   assign cfg_mode_e = mode_e'(cfg_mode);

   // Indices at or above NCH match no channel, so such writes are dropped.
   always_comb begin
      cfg_we_ch = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cfg_we_ch[i] = cfg_we && (cfg_ch == CW'(i));
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      pulse_chan #(
         .WIDTH          (WIDTH),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .start      (start[g]),
         .cfg_we     (cfg_we_ch[g]),
         .cfg_period (cfg_period),
         .cfg_mode   (cfg_mode_e),
         .done       (done[g]),
         .running    (running[g])
      );
   end

endmodule

// File: tb/tb_pulse_timer.sv
// Randomized and directed checks of pulse_timer against an elapsed-tick
// reference model: count is elapsed mod (period+1); one-shot ends after period+1 ticks.
module tb_pulse_timer;

   localparam int unsigned NCH   = 3;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEFP  = 3;

   logic             clk = 1'b0;
   logic             rst, en, cfg_we, cfg_mode;
   logic [NCH-1:0]   start;
   logic [1:0]       cfg_ch;
   logic [WIDTH-1:0] cfg_period;
   logic [NCH-1:0]   done, running;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          armed = 1'b0;

   longint      m_elapsed [NCH];
   int unsigned m_per     [NCH];
   bit          m_one     [NCH];
   bit          m_run     [NCH];

   pulse_timer #(
      .NCH            (NCH),
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .start      (start),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_mode   (cfg_mode),
      .done       (done),
      .running    (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_done();
      logic [31:0] v = '0;
      for (int i = 0; i < NCH; i++) begin
         v[i] = m_run[i] && ((m_elapsed[i] % (longint'(m_per[i]) + 1)) == longint'(m_per[i]));
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_run();
      logic [31:0] v = '0;
      for (int i = 0; i < NCH; i++) v[i] = m_run[i];
      return v;
   endfunction

   task automatic model_step(input bit r, input bit e, input logic [NCH-1:0] s,
                             input bit we, input logic [1:0] ch,
                             input logic [WIDTH-1:0] p, input bit m);
      for (int i = 0; i < NCH; i++) begin
         if (r) begin
            m_elapsed[i] = 0; m_per[i] = DEFP; m_one[i] = 1'b0; m_run[i] = 1'b1;
         end else if (we && int'(ch) == i) begin
            m_per[i] = p; m_one[i] = m; m_elapsed[i] = 0; m_run[i] = s[i];
         end else if (s[i] && !m_run[i]) begin
            m_run[i] = 1'b1; m_elapsed[i] = 0;
         end else if (e && m_run[i]) begin
            m_elapsed[i]++;
            if (m_one[i] && m_elapsed[i] == longint'(m_per[i]) + 1) begin
               m_run[i] = 1'b0; m_elapsed[i] = 0;
            end
         end
      end
   endtask

   // Called at a negedge: drive, check current state, clock once, advance model.
   task automatic cycle(input bit r, input bit e, input logic [NCH-1:0] s,
                        input bit we, input logic [1:0] ch,
                        input logic [WIDTH-1:0] p, input bit m);
      rst = r; en = e; start = s; cfg_we = we; cfg_ch = ch; cfg_period = p; cfg_mode = m;
      #1;
      if (armed) begin
         chk("done", 32'(done), exp_done());
         chk("running", 32'(running), exp_run());
      end
      @(posedge clk);
      model_step(r, e, s, we, ch, p, m);
      if (r) armed = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input bit e, input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, e, '0, 1'b0, 2'd0, '0, 1'b0);
   endtask

   initial begin
      int unsigned pulses;
      @(negedge clk);

      // Legacy free-running behaviour after reset
      cycle(1'b1, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0);
      cycle(1'b1, 1'b1, '1, 1'b1, 2'd1, 4'd9, 1'b1);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_running", 32'(running), 32'h7);
      for (int k = 1; k <= 12; k++) begin
         #1;
         chk("legacy_done", 32'(done), (k % 4 == 0) ? 32'h7 : 32'h0);
         cycle(1'b0, 1'b1, '0, 1'b0, 2'd0, '0, 1'b0);
      end

      // One-shot ch1, period 5
      cycle(1'b0, 1'b1, '0, 1'b1, 2'd1, 4'd5, 1'b1);
      idle(1'b1, 2);
      cycle(1'b0, 1'b1, 3'b010, 1'b0, 2'd0, '0, 1'b0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (done[1]) pulses++;
         cycle(1'b0, 1'b1, '0, 1'b0, 2'd0, '0, 1'b0);
      end
      chk("oneshot_pulses", 32'(pulses), 32'd1);
      chk("oneshot_stopped", 32'(running[1]), 32'd0);

      // Enable freeze on ch0 at count 2
      cycle(1'b1, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0);
      idle(1'b1, 2);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("frozen_done0", 32'(done[0]), 32'd0);
         cycle(1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0);
      end
      cycle(1'b0, 1'b1, '0, 1'b0, 2'd0, '0, 1'b0);
      chk("resume_done0", 32'(done[0]), 32'd1);

      // Period 0 continuous with simultaneous start on ch2
      cycle(1'b0, 1'b1, 3'b100, 1'b1, 2'd2, 4'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("p0_done2", 32'(done[2]), 32'd1);
         cycle(1'b0, (k % 2) == 0, '0, 1'b0, 2'd0, '0, 1'b0);
      end

      // Period 0 one-shot on ch2
      cycle(1'b0, 1'b1, '0, 1'b1, 2'd2, 4'd0, 1'b1);
      cycle(1'b0, 1'b1, 3'b100, 1'b0, 2'd0, '0, 1'b0);
      idle(1'b1, 3);

      // Out-of-range write and retrigger while running
      cycle(1'b0, 1'b1, '0, 1'b1, 2'd3, 4'd1, 1'b1);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 3'b001, 1'b0, 2'd0, '0, 1'b0);

      // Reset mid-count on a one-shot channel
      cycle(1'b0, 1'b1, 3'b001, 1'b1, 2'd0, 4'd9, 1'b1);
      idle(1'b1, 4);
      cycle(1'b1, 1'b1, '0, 1'b0, 2'd0, '0, 1'b0);
      idle(1'b1, 8);

      // All-ones period wraps cleanly
      cycle(1'b0, 1'b1, 3'b010, 1'b1, 2'd1, 4'hF, 1'b0);
      idle(1'b1, 40);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         bit               r, e, we, m;
         logic [NCH-1:0]   s;
         logic [1:0]       ch;
         logic [WIDTH-1:0] p;
         r  = ($urandom_range(0, 199) == 0);
         e  = ($urandom_range(0, 9) < 8);
         we = ($urandom_range(0, 19) == 0);
         s  = '0;
         for (int i = 0; i < NCH; i++) s[i] = ($urandom_range(0, 14) == 0);
         ch = 2'($urandom_range(0, 3));
         p  = ($urandom_range(0, 7) == 0) ? 4'hF : WIDTH'($urandom_range(0, 6));
         m  = 1'($urandom_range(0, 1));
         cycle(r, e, s, we, ch, p, m);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
